// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Round-robin arbiter/sequencer sharing one iterative Q0.16 fractional divider
// among N_REQ requesters. One operation is in flight at a time. Degenerate
// operands (den==0, num>=den) are answered directly without the divider, and
// a divider that never reports completion is cut off after 32 wait cycles.
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   req_valid       : per-requester request, held until req_ready is seen
//   req_num/req_den : per-requester 16-bit operands, slice i = [16i+15:16i]
//   req_ready       : combinational one-hot accept, only in IDLE
//   rsp_valid       : registered one-hot, one-cycle response pulse
//   rsp_data        : registered Q0.16 quotient (0xFFFF on any error)
//   rsp_flags       : registered {tmo, ovf, div0}
//   busy            : registered, high in every state except IDLE
//   div_start       : registered one-cycle launch pulse to the divider
//   div_num/div_den : registered divider operands, held LAUNCH..WAIT
//   div_quotient    : divider result, sampled only with div_done
//   div_done        : divider one-cycle completion pulse
// -----------------------------------------------------------------------------
module div_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [16*N_REQ-1:0]  req_num,
  input  logic [16*N_REQ-1:0]  req_den,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_data,
  output logic [2:0]           rsp_flags,
  output logic                 busy,
  output logic                 div_start,
  output logic [15:0]          div_num,
  output logic [15:0]          div_den,
  input  logic [15:0]          div_quotient,
  input  logic                 div_done
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              state_q;
  logic [IW-1:0]       ptr_q;
  logic [IW-1:0]       win_q;
  logic [4:0]          tmo_cnt_q;
  logic [N_REQ-1:0]    rsp_valid_q;
  logic [15:0]         rsp_data_q;
  logic [2:0]          rsp_flags_q;
  logic                busy_q;
  logic                div_start_q;
  logic [15:0]         div_num_q;
  logic [15:0]         div_den_q;

  logic                win_found_s;
  logic [IW-1:0]       win_idx_s;
  logic [IW-1:0]       ptr_nxt_s;
  logic [15:0]         sel_num_s;
  logic [15:0]         sel_den_s;
  logic [N_REQ-1:0]    req_ready_s;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin search: first set request at or above the pointer, wrapping.
  always_comb begin
    int   cand;
    logic hit;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand        = 0;
    hit         = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      cand = (cand >= N_REQ) ? (cand - N_REQ) : cand;
      hit  = !win_found_s && req_valid[IW'(cand)];
      win_idx_s   = hit ? IW'(cand) : win_idx_s;
      win_found_s = win_found_s | hit;
    end
  end

  // Winner operands, pointer successor and the combinational accept strobe.
  always_comb begin
    sel_num_s = req_num[int'(win_idx_s)*16 +: 16];
    sel_den_s = req_den[int'(win_idx_s)*16 +: 16];
    if (int'(win_idx_s) == N_REQ - 1) begin
      ptr_nxt_s = '0;
    end else begin
      ptr_nxt_s = win_idx_s + IW'(1);
    end
    if ((state_q == S_IDLE) && win_found_s) begin
      req_ready_s = onehot(win_idx_s);
    end else begin
      req_ready_s = '0;
    end
  end

  // Sequencer FSM with all externally visible outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      tmo_cnt_q   <= 5'd0;
      rsp_valid_q <= '0;
      rsp_data_q  <= 16'h0000;
      rsp_flags_q <= 3'b000;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
      div_num_q   <= 16'h0000;
      div_den_q   <= 16'h0000;
    end else begin
      // Pulses default low; they are raised only on the entering transition.
      div_start_q <= 1'b0;
      rsp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found_s) begin
            ptr_q  <= ptr_nxt_s;
            win_q  <= win_idx_s;
            busy_q <= 1'b1;
            if (sel_den_s == 16'h0000) begin
              state_q     <= S_RESP;
              rsp_data_q  <= 16'hFFFF;
              rsp_flags_q <= 3'b001;
              rsp_valid_q <= onehot(win_idx_s);
            end else if (sel_num_s >= sel_den_s) begin
              // Quotient would be >= 1.0, not representable in Q0.16.
              state_q     <= S_RESP;
              rsp_data_q  <= 16'hFFFF;
              rsp_flags_q <= 3'b010;
              rsp_valid_q <= onehot(win_idx_s);
            end else begin
              state_q     <= S_LAUNCH;
              div_start_q <= 1'b1;
              div_num_q   <= sel_num_s;
              div_den_q   <= sel_den_s;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          state_q   <= S_WAIT;
          tmo_cnt_q <= 5'd0;
        end
        S_WAIT: begin
          if (div_done) begin
            state_q     <= S_RESP;
            rsp_data_q  <= div_quotient;
            rsp_flags_q <= 3'b000;
            rsp_valid_q <= onehot(win_q);
          end else if (tmo_cnt_q == 5'd31) begin
            // 32nd consecutive WAIT cycle without completion.
            state_q     <= S_RESP;
            rsp_data_q  <= 16'hFFFF;
            rsp_flags_q <= 3'b100;
            rsp_valid_q <= onehot(win_q);
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 5'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = busy_q;
  assign div_start = div_start_q;
  assign div_num   = div_num_q;
  assign div_den   = div_den_q;

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_num;
  logic [16*N-1:0] req_den;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [15:0]     rsp_data;
  logic [2:0]      rsp_flags;
  logic            busy;
  logic            div_start;
  logic [15:0]     div_num;
  logic [15:0]     div_den;
  logic [15:0]     div_quotient;
  logic            div_done;

  int checks = 0;
  int errors = 0;

  // Divider stub: done 17 cycles after the start pulse, true Q0.16 quotient.
  logic [4:0] stub_cnt;
  logic       stub_en;
  logic [31:0] stub_q32;

  div_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .busy(busy), .div_start(div_start),
    .div_num(div_num), .div_den(div_den),
    .div_quotient(div_quotient), .div_done(div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               stub_cnt <= 5'd0;
    else if (div_start)       stub_cnt <= 5'd17;
    else if (stub_cnt != 5'd0) stub_cnt <= stub_cnt - 5'd1;
  end

  always_comb begin
    stub_q32 = 32'd0;
    if (div_den != 16'h0000) stub_q32 = {div_num, 16'h0000} / {16'h0000, div_den};
    div_quotient = stub_q32[15:0];
    div_done     = stub_en && (stub_cnt == 5'd1);
  end

  typedef struct {
    int          idx;
    logic [15:0] num;
    logic [15:0] den;
    logic [15:0] data;
    logic [2:0]  flags;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  function automatic logic [63:0] all_outs();
    return {3'b000, req_ready, rsp_valid, rsp_data, rsp_flags, busy, div_start, div_num, div_den};
  endfunction

  // One isolated operation: accept in cycle 0, check latency and payload.
  task automatic run_op(input vec_t v);
    int          rsp_cyc, starts, start_cyc, busy_low;
    logic [N-1:0] rv;
    logic [15:0] d;
    logic [2:0]  f;
    rsp_cyc = -1; starts = 0; start_cyc = -1; busy_low = 0;
    rv = '0; d = 16'h0; f = 3'b0;
    @(posedge clk); #1;
    req_valid = oh(v.idx);
    req_num[16*v.idx +: 16] = v.num;
    req_den[16*v.idx +: 16] = v.den;
    @(negedge clk);
    chk("ready_c0", req_ready, oh(v.idx));
    chk("busy_c0", busy, 1'b0);
    for (int c = 1; c <= 40 && rsp_cyc < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) req_valid = '0;
      @(negedge clk);
      if (div_start) begin
        starts++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (!busy) busy_low++;
      if (rsp_valid != '0) begin
        rsp_cyc = c; rv = rsp_valid; d = rsp_data; f = rsp_flags;
      end
    end
    chk("rsp_cycle", rsp_cyc, v.lat);
    chk("rsp_valid", rv, oh(v.idx));
    chk("rsp_data", d, v.data);
    chk("rsp_flags", f, v.flags);
    chk("start_count", starts, (v.lat > 1) ? 1 : 0);
    if (v.lat > 1) chk("start_cycle", start_cyc, 1);
    chk("busy_gaps", busy_low, 0);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_rsp_valid", rsp_valid, '0);
    chk("hold_data", rsp_data, v.data);
    chk("hold_flags", rsp_flags, v.flags);
  endtask

  initial begin
    int          acc_cyc[6];
    logic [N-1:0] acc_who[6];
    logic [N-1:0] rdy;
    int          na;
    int          stray;

    vecs[0] = '{0, 16'h4000, 16'h8000, 16'h8000, 3'b000, 19};
    vecs[1] = '{1, 16'h1000, 16'h4000, 16'h4000, 3'b000, 19};
    vecs[2] = '{1, 16'h0001, 16'hFFFF, 16'h0001, 3'b000, 19};
    vecs[3] = '{2, 16'h1234, 16'h0000, 16'hFFFF, 3'b001, 1};
    vecs[4] = '{3, 16'h8000, 16'h8000, 16'hFFFF, 3'b010, 1};
    vecs[5] = '{0, 16'h0000, 16'h0000, 16'hFFFF, 3'b001, 1};
    vecs[6] = '{1, 16'hFFFE, 16'hFFFF, 16'hFFFE, 3'b000, 19};
    vecs[7] = '{2, 16'h0000, 16'h0001, 16'h0000, 3'b000, 19};
    vecs[8] = '{3, 16'h0005, 16'h0004, 16'hFFFF, 3'b010, 1};

    rst_n = 1'b0; req_valid = '0; req_num = '0; req_den = '0; stub_en = 1'b1;
    #2;
    chk("reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // Divider never completes: timeout response.
    stub_en = 1'b0;
    run_op('{0, 16'h4000, 16'h8000, 16'hFFFF, 3'b100, 34});
    stub_en = 1'b1;

    // Round-robin order and back-to-back throughput from a fresh reset.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_num[16*i +: 16] = 16'h1000;
      req_den[16*i +: 16] = 16'h2000;
    end
    req_valid = 4'hF;
    na = 0;
    for (int c = 0; c < 200 && na < 6; c++) begin
      @(negedge clk);
      rdy = req_ready;
      if (rdy != '0) begin
        acc_cyc[na] = c; acc_who[na] = rdy; na++;
      end
      @(posedge clk); #1;
      req_valid = req_valid & ~rdy;
      if (na == 4 && c == 61) req_valid = 4'b0101;
    end
    chk("rr_accept_count", na, 6);
    if (na == 6) begin
      chk("rr_who0", acc_who[0], 4'b0001); chk("rr_cyc0", acc_cyc[0], 0);
      chk("rr_who1", acc_who[1], 4'b0010); chk("rr_cyc1", acc_cyc[1], 20);
      chk("rr_who2", acc_who[2], 4'b0100); chk("rr_cyc2", acc_cyc[2], 40);
      chk("rr_who3", acc_who[3], 4'b1000); chk("rr_cyc3", acc_cyc[3], 60);
      chk("rr_who4", acc_who[4], 4'b0001); chk("rr_cyc4", acc_cyc[4], 80);
      chk("rr_who5", acc_who[5], 4'b0100); chk("rr_cyc5", acc_cyc[5], 100);
    end
    repeat (25) @(posedge clk);

    // Reset in cycle 10 of a normal operation on req 0 (pointer moves to 1).
    @(posedge clk); #1;
    req_num[15:0] = 16'h4000; req_den[15:0] = 16'h8000;
    req_valid = 4'b0001;
    @(negedge clk);
    chk("mid_ready", req_ready, 4'b0001);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) req_valid = '0;
    end
    chk("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rsp_valid != '0 || busy) stray++;
    end
    chk("no_rsp_after_reset", stray, 0);
    @(posedge clk); #1;
    req_num[47:32] = 16'h1000; req_den[47:32] = 16'h2000;
    req_valid = 4'b0101;
    @(negedge clk);
    chk("ptr_after_reset", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0100;
    rdy = '0;
    for (int c = 0; c < 60 && rdy == '0; c++) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk); #1;
    end
    req_valid = '0;
    chk("second_after_reset", rdy, 4'b0100);
    repeat (25) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
